// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters.
//
// A three-state FSM (idle / exec / resp) grants one request, latches its
// operands and control, presents them to the external ALU for one cycle,
// registers the result and zero flag, and holds the response until the
// owning requester accepts it. No arithmetic is done here.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// always wins a simultaneous request); default is round-robin.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     per-requester request handshake (2 bits)
//   req_in1_*/req_in2_*     per-requester operands
//   req_ctrl_*              per-requester alu_control
//   alu_in1/alu_in2         latched operands to the ALU
//   alu_control             latched control to the ALU
//   alu_result/alu_zero     ALU outputs
//   rsp_valid/rsp_ready     per-requester response handshake (2 bits)
//   rsp_result/rsp_zero     registered ALU result and zero flag
//   busy                    registered, high while not idle
module alu_arbiter #(
  parameter int unsigned REG_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [REG_WIDTH-1:0] req_in1_0,
  input  logic [REG_WIDTH-1:0] req_in1_1,
  input  logic [REG_WIDTH-1:0] req_in2_0,
  input  logic [REG_WIDTH-1:0] req_in2_1,
  input  logic [3:0]           req_ctrl_0,
  input  logic [3:0]           req_ctrl_1,
  output logic [REG_WIDTH-1:0] alu_in1,
  output logic [REG_WIDTH-1:0] alu_in2,
  output logic [3:0]           alu_control,
  input  logic [REG_WIDTH-1:0] alu_result,
  input  logic                 alu_zero,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [REG_WIDTH-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e               state_q, state_d;
  logic                 owner_q;
  logic [REG_WIDTH-1:0] in1_q, in2_q, result_q;
  logic [3:0]           ctrl_q;
  logic                 zero_q;
  logic                 busy_q;
  logic                 winner;
  logic                 grant;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is valid.
  always_comb begin
    winner = ~req_valid[0];
  end
`else
  logic prio_q;

  // prio_q names the preferred requester on contention; a lone request wins.
  always_comb begin
    if (&req_valid) begin
      winner = prio_q;
    end else begin
      winner = req_valid[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (grant) begin
      prio_q <= ~winner;
    end
  end
`endif

  // Reset masks the grant so no handshake is reported for a discarded cycle.
  always_comb begin
    grant = (state_q == StIdle) && (|req_valid) && !reset;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready[owner_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, operand, owner and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      ctrl_q   <= 4'b0000;
      result_q <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      if (grant) begin
        owner_q <= winner;
        in1_q   <= winner ? req_in1_1 : req_in1_0;
        in2_q   <= winner ? req_in2_1 : req_in2_0;
        ctrl_q  <= winner ? req_ctrl_1 : req_ctrl_0;
      end
      if (state_q == StExec) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
    end
  end

  // Outputs.
  always_comb begin
    req_ready   = grant ? {winner, ~winner} : 2'b00;
    rsp_valid   = ((state_q == StResp) && !reset) ? {owner_q, ~owner_q} : 2'b00;
    alu_in1     = in1_q;
    alu_in2     = in2_q;
    alu_control = ctrl_q;
    rsp_result  = result_q;
    rsp_zero    = zero_q;
    busy        = busy_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0] req_in1_0, req_in1_1, req_in2_0, req_in2_1;
  logic [3:0]   req_ctrl_0, req_ctrl_1, alu_control;
  logic [W-1:0] alu_in1, alu_in2, alu_result, rsp_result;
  logic         alu_zero, rsp_zero, busy;

  always #5 clk = ~clk;

  alu_arbiter #(.REG_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1_0(req_in1_0), .req_in1_1(req_in1_1),
    .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Stand-in for the shared ALU.
  function automatic logic [W-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_in1, alu_in2, alu_control);
    alu_zero   = (alu_result == '0);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] c);
    if (id == 0) begin
      req_in1_0 = a; req_in2_0 = b; req_ctrl_0 = c;
    end else begin
      req_in1_1 = a; req_in2_1 = b; req_ctrl_1 = c;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [3:0]   ctrl;
    logic [W-1:0] res;
    logic         zero;
  } vec_t;

  vec_t vecs[5];

  // Random-phase model state.
  bit           m_busy, m_prio, m_owner;
  int           m_gcyc;
  logic [W-1:0] m_in1, m_in2, m_res;
  logic [3:0]   m_ctrl;
  bit [1:0]     pend, hs;

  function automatic bit pick(input logic [1:0] v, input bit prio);
    if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return prio;
`endif
    end
    return v[1];
  endfunction

  initial begin
    int order[4];
    int n;
    logic [3:0] ctrls[4];
    ctrls[0] = 4'b0000; ctrls[1] = 4'b0001; ctrls[2] = 4'b0010; ctrls[3] = 4'b0110;

    vecs[0] = '{0, 64'd5, 64'd3, 4'b0010, 64'd8, 1'b0};
    vecs[1] = '{1, 64'd7, 64'd7, 4'b0110, 64'd0, 1'b1};
    vecs[2] = '{0, 64'hF0, 64'h3C, 4'b0000, 64'h30, 1'b0};
    vecs[3] = '{1, 64'hF0, 64'h0F, 4'b0001, 64'hFF, 1'b0};
    vecs[4] = '{0, 64'd3, 64'd5, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};

    set_req(0, '0, '0, 4'b0);
    set_req(1, '0, '0, 4'b0);
    do_reset();

    // Idle after reset.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_req_ready", W'(req_ready), 0);
      check("rst_rsp_valid", W'(rsp_valid), 0);
      check("rst_busy", W'(busy), 0);
      check("rst_alu_in1", alu_in1, 0);
      check("rst_alu_control", W'(alu_control), 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_zero", W'(rsp_zero), 0);
    end
    tick();

    // Single operations from the vector table.
    rsp_ready = 2'b11;
    for (int i = 0; i < 5; i++) begin
      set_req(vecs[i].id, vecs[i].in1, vecs[i].in2, vecs[i].ctrl);
      req_valid = (vecs[i].id == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      check("vec_req_ready", W'(req_ready), W'(req_valid));
      check("vec_busy_c0", W'(busy), 0);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      check("vec_alu_in1", alu_in1, vecs[i].in1);
      check("vec_alu_in2", alu_in2, vecs[i].in2);
      check("vec_alu_control", W'(alu_control), W'(vecs[i].ctrl));
      check("vec_busy_c1", W'(busy), 1);
      check("vec_rsp_valid_c1", W'(rsp_valid), 0);
      tick();
      @(negedge clk);
      check("vec_rsp_valid", W'(rsp_valid), (vecs[i].id == 0) ? 1 : 2);
      check("vec_rsp_result", rsp_result, vecs[i].res);
      check("vec_rsp_zero", W'(rsp_zero), W'(vecs[i].zero));
      tick();
      @(negedge clk);
      check("vec_idle_busy", W'(busy), 0);
      check("vec_idle_rsp_valid", W'(rsp_valid), 0);
      tick();
    end

    // Contention: both requesters valid continuously.
    do_reset();
    set_req(0, 64'd1, 64'd1, 4'b0010);
    set_req(1, 64'd2, 64'd2, 4'b0010);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        check("cont_onehot", W'($countones(req_ready)), 1);
        order[n] = req_ready[1] ? 1 : 0;
        n++;
      end
      tick();
    end
    check("cont_grants", W'(n), 4);
    for (int k = 0; k < n; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("cont_order", W'(order[k]), 0);
`else
      check("cont_order", W'(order[k]), W'(k % 2));
`endif
    end
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) tick();

    // Back-pressure, with the non-owner's rsp_ready high and a waiting request.
    do_reset();
    set_req(0, 64'd10, 64'd20, 4'b0010);
    req_valid = 2'b01;
    rsp_ready = 2'b10;
    @(negedge clk);
    check("bp_req_ready0", W'(req_ready), 1);
    tick();
    set_req(1, 64'd4, 64'd4, 4'b0010);
    req_valid = 2'b10;
    @(negedge clk);
    check("bp_exec_req_ready", W'(req_ready), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", W'(rsp_valid), 1);
      check("bp_rsp_result", rsp_result, 64'd30);
      check("bp_req_ready", W'(req_ready), 0);
      tick();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_rsp_valid_accept", W'(rsp_valid), 1);
    tick();
    @(negedge clk);
    check("bp_idle_busy", W'(busy), 0);
    check("bp_idle_rsp_valid", W'(rsp_valid), 0);
    check("bp_waiting_granted", W'(req_ready), 2);
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) tick();

    // Reset during EXEC discards the op and clears prio.
    set_req(0, 64'd9, 64'd9, 4'b0010);
    req_valid = 2'b01;
    @(negedge clk);
    check("rx_req_ready", W'(req_ready), 1);
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rx_alu_in1", alu_in1, 0);
    check("rx_alu_in2", alu_in2, 0);
    check("rx_alu_control", W'(alu_control), 0);
    check("rx_busy", W'(busy), 0);
    check("rx_rsp_result", rsp_result, 0);
    check("rx_rsp_zero", W'(rsp_zero), 0);
    for (int k = 0; k < 3; k++) begin
      check("rx_no_rsp", W'(rsp_valid), 0);
      tick();
      @(negedge clk);
    end
    tick();
    set_req(1, 64'd1, 64'd2, 4'b0010);
    req_valid = 2'b11;
    @(negedge clk);
    check("rx_prio_reset", W'(req_ready), 1);
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_busy = 0; m_prio = 0; m_owner = 0; m_gcyc = 0;
    m_in1 = '0; m_in2 = '0; m_ctrl = '0; m_res = '0;
    pend = 2'b00; hs = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0] exp_rr, exp_rv;
      bit w;
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && hs[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          logic [W-1:0] a, b;
          a = {$urandom, $urandom};
          b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
          set_req(i, a, b, ctrls[$urandom_range(0, 3)]);
          pend[i] = 1'b1;
        end
      end
      req_valid = pend;
      rsp_ready = 2'($urandom_range(0, 3));
      @(negedge clk);
      w = pick(req_valid, m_prio);
      exp_rr = (!m_busy && req_valid != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
      exp_rv = (m_busy && cyc >= m_gcyc + 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_req_ready", W'(req_ready), W'(exp_rr));
      check("rnd_rsp_valid", W'(rsp_valid), W'(exp_rv));
      check("rnd_busy", W'(busy), W'(m_busy));
      check("rnd_alu_in1", alu_in1, m_in1);
      check("rnd_alu_in2", alu_in2, m_in2);
      check("rnd_alu_control", W'(alu_control), W'(m_ctrl));
      if (exp_rv != 2'b00) begin
        check("rnd_rsp_result", rsp_result, m_res);
        check("rnd_rsp_zero", W'(rsp_zero), W'(m_res == '0));
      end
      hs = exp_rr;
      if (exp_rr != 2'b00) begin
        m_busy  = 1;
        m_gcyc  = cyc;
        m_owner = w;
        m_in1   = w ? req_in1_1 : req_in1_0;
        m_in2   = w ? req_in2_1 : req_in2_0;
        m_ctrl  = w ? req_ctrl_1 : req_ctrl_0;
        m_res   = alu_fn(m_in1, m_in2, m_ctrl);
`ifndef ALU_ARB_FIXED_PRIO_EN
        m_prio  = ~w;
`endif
      end else if (exp_rv != 2'b00 && rsp_ready[m_owner]) begin
        m_busy = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
